seq_tx: RTL and testbench

Transmitter for the 2-bit symbol sequence 01 → 10 → 11. It is the sending counterpart of the team's sequence detector. On a start request, the block emits a programmable number of frames onto a registered 2-bit bus. Frames are separated by a configurable number of idle-symbol cycles, so a downstream detector raises its match output exactly once per frame. It sits between control logic that issues start/count and the 2-bit symbol link.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_gap_timer.sv | 27 ++
 rtl/seq_tx.sv | 111 +++++++++++
 tb/tb_seq_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 2-bit sequence link (01 -> 10 -> 11):
// symbol constants, transmitter state type and state-to-symbol decode.
package seq_pkg;

   localparam logic [1:0] SYM_IDLE = 2'b00;
   localparam logic [1:0] SYM_1    = 2'b01;
   localparam logic [1:0] SYM_2    = 2'b10;
   localparam logic [1:0] SYM_3    = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      S1,
      S2,
      S3,
      GAP
   } tx_state_t;

   function automatic logic [1:0] state_sym(input tx_state_t s, input logic [1:0] idle_sym);
      case (s)
         S1:      return SYM_1;
         S2:      return SYM_2;
         S3:      return SYM_3;
         default: return idle_sym;
      endcase
   endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter timing the idle gap between frames; zero flags expiry.
module seq_gap_timer #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/seq_tx.sv
// Sequence transmitter: emits `count` frames of 01,10,11 separated by GAP_CYCLES
// idle symbols. Optional abort input enabled by defining SEQ_TX_ABORT_EN.
module seq_tx
   import seq_pkg::*;
#(
   parameter logic [1:0]  IDLE_SYM   = SYM_IDLE,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned COUNT_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
`ifdef SEQ_TX_ABORT_EN
   input  logic               abort,
`endif
   output logic [1:0]         out_bits,
   output logic               valid,
   output logic               busy,
   output logic               done
);

   // Timer needs at least one bit even when gaps are disabled.
   localparam int unsigned     GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   tx_state_t          state, state_nxt;
   logic [COUNT_W-1:0] remaining, rem_nxt;
   logic               done_nxt;
   logic               gap_load, gap_en, gap_zero;
   logic               abort_req;

`ifdef SEQ_TX_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   seq_gap_timer #(
      .W(GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .en       (gap_en),
      .load_val (GAP_LOAD),
      .zero     (gap_zero)
   );

   always_comb begin
      state_nxt = state;
      rem_nxt   = remaining;
      done_nxt  = 1'b0;
      gap_load  = 1'b0;
      gap_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start && (count != '0)) begin
               state_nxt = S1;
               rem_nxt   = count;
            end
         end
         S1: state_nxt = S2;
         S2: state_nxt = S3;
         S3: begin
            rem_nxt = remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
               state_nxt = S1;
            end else begin
               state_nxt = GAP;
               gap_load  = 1'b1;
            end
         end
         GAP: begin
            if (gap_zero) state_nxt = S1;
            else          gap_en    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort overrides every transition out of a busy state and suppresses done.
      if (abort_req && (state != IDLE)) begin
         state_nxt = IDLE;
         rem_nxt   = '0;
         done_nxt  = 1'b0;
         gap_load  = 1'b0;
         gap_en    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         remaining <= '0;
         out_bits  <= IDLE_SYM;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= rem_nxt;
         out_bits  <= state_sym(state_nxt, IDLE_SYM);
         valid     <= (state_nxt == S1) || (state_nxt == S2) || (state_nxt == S3);
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: three instances with gaps of 1, 2 and 0 cycles,
// each checked cycle by cycle against a frame-level expected-output queue.
module tb_seq_tx;

   typedef struct packed {
      logic [1:0] bits;
      logic       valid;
      logic       busy;
      logic       done;
   } exp_t;

   localparam exp_t EXP_IDLE = 5'b00_0_0_0;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] count = 4'd0;
   logic       abort_now;
`ifdef SEQ_TX_ABORT_EN
   logic       abort = 1'b0;
   assign abort_now = abort;
`else
   assign abort_now = 1'b0;
`endif

   logic [1:0] ob [3];
   logic       vl [3];
   logic       bz [3];
   logic       dn [3];

   exp_t q [3][$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_tx #(.IDLE_SYM(2'b00), .GAP_CYCLES(1), .COUNT_W(4)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .count(count),
`ifdef SEQ_TX_ABORT_EN
      .abort(abort),
`endif
      .out_bits(ob[0]), .valid(vl[0]), .busy(bz[0]), .done(dn[0]));

   seq_tx #(.IDLE_SYM(2'b00), .GAP_CYCLES(2), .COUNT_W(4)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .count(count),
`ifdef SEQ_TX_ABORT_EN
      .abort(abort),
`endif
      .out_bits(ob[1]), .valid(vl[1]), .busy(bz[1]), .done(dn[1]));

   seq_tx #(.IDLE_SYM(2'b00), .GAP_CYCLES(0), .COUNT_W(4)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .count(count),
`ifdef SEQ_TX_ABORT_EN
      .abort(abort),
`endif
      .out_bits(ob[2]), .valid(vl[2]), .busy(bz[2]), .done(dn[2]));

   function automatic int gap_of(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 0;
      endcase
   endfunction

   // Whole transfer laid out as the cycle-by-cycle output it must produce.
   function automatic void push_transfer(input int i, input int k);
      int g;
      g = gap_of(i);
      for (int f = 0; f < k; f++) begin
         q[i].push_back(5'b01_1_1_0);
         q[i].push_back(5'b10_1_1_0);
         q[i].push_back(5'b11_1_1_0);
         if (f < k - 1)
            for (int j = 0; j < g; j++) q[i].push_back(5'b00_0_1_0);
      end
      q[i].push_back(5'b00_0_0_1);
   endfunction

   function automatic void clear_all();
      for (int i = 0; i < 3; i++) q[i].delete();
   endfunction

   // Reference model: a DUT is idle exactly when its queue has drained.
   always @(posedge clk) begin
      if (!reset) begin
         clear_all();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (abort_now && (q[i].size() != 0))
               q[i].delete();
            else if ((q[i].size() == 0) && start && (count != 4'd0))
               push_transfer(i, int'(count));
         end
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 3; m++) begin
         exp_t e;
         exp_t got;
         if (q[m].size() != 0) e = q[m].pop_front();
         else                  e = EXP_IDLE;
         got = {ob[m], vl[m], bz[m], dn[m]};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL dut%0d_output t=%0t got bits=%b valid=%b busy=%b done=%b required bits=%b valid=%b busy=%b done=%b",
                     m, $time, got.bits, got.valid, got.busy, got.done, e.bits, e.valid, e.busy, e.done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k);
      start = 1'b1;
      count = 4'(k);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (((q[0].size() + q[1].size() + q[2].size()) != 0) && (n < budget)) begin
         tick();
         n++;
      end
      if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout t=%0t pending=%0d required=0", $time,
                  q[0].size() + q[1].size() + q[2].size());
         clear_all();
      end
      tick();
   endtask

   initial begin
      #2 reset = 1'b0;
      clear_all();
      repeat (3) tick();
      reset = 1'b1;
      tick();

      send(1);  wait_idle(100);
      send(3);  wait_idle(100);
      send(2);  wait_idle(100);

      start = 1'b1; count = 4'd0; tick(); start = 1'b0;
      repeat (3) tick();

      send(5);
      repeat (4) begin
         start = 1'b1;
         count = 4'($urandom_range(1, 15));
         tick();
      end
      start = 1'b0;
      wait_idle(100);

      send(15); wait_idle(200);

      start = 1'b1; count = 4'd2;
      repeat (30) tick();
      start = 1'b0;
      wait_idle(100);

      send(3);
      tick();
      reset = 1'b0;
      clear_all();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      send(2);  wait_idle(100);

`ifdef SEQ_TX_ABORT_EN
      send(4);
      repeat (3) tick();
      abort = 1'b1; tick(); abort = 1'b0;
      repeat (4) tick();
      abort = 1'b1; start = 1'b1; count = 4'd2; tick();
      abort = 1'b0; start = 1'b0;
      wait_idle(100);
`endif

      for (int r = 0; r < 400; r++) begin
         start = ($urandom_range(0, 3) == 0);
         count = 4'($urandom_range(0, 15));
`ifdef SEQ_TX_ABORT_EN
         abort = ($urandom_range(0, 40) == 0);
`endif
         tick();
      end
      start = 1'b0;
`ifdef SEQ_TX_ABORT_EN
      abort = 1'b0;
`endif
      wait_idle(300);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
